// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I integer core with separate instruction and data ports.
// One instruction retires per clk edge; taken branches/jumps land after one delay slot.
module mips_cpu_harvard #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_src_t;

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        active_q, active_d;
    logic [31:0] gpr_q [0:31];

    // clk_enable is reserved; the core advances on every edge regardless.
    logic unused_clk_enable;
    assign unused_clk_enable = clk_enable;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] instr_index;

    assign opcode      = instr_readdata[31:26];
    assign rs          = instr_readdata[25:21];
    assign rt          = instr_readdata[20:16];
    assign rd          = instr_readdata[15:11];
    assign shamt       = instr_readdata[10:6];
    assign funct       = instr_readdata[5:0];
    assign imm         = instr_readdata[15:0];
    assign instr_index = instr_readdata[25:0];

    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [31:0] pc_plus4, pc_plus8, seq_pc;

    assign rs_val   = (rs == 5'd0) ? 32'h0 : gpr_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'h0 : gpr_q[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    // A pending target from the previous instruction wins over fall-through.
    assign seq_pc   = pend_valid_q ? pend_target_q : pc_plus4;

    alu_op_t     alu_op;
    wb_src_t     wb_src;
    logic        use_imm, zext_imm, var_shift;
    logic        wr_en, is_load, is_store, take;
    logic [4:0]  wr_addr;
    logic [31:0] target;

    always_comb begin
        alu_op    = ALU_ADD;
        wb_src    = WB_ALU;
        use_imm   = 1'b0;
        zext_imm  = 1'b0;
        var_shift = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = rd;
        is_load   = 1'b0;
        is_store  = 1'b0;
        take      = 1'b0;
        target    = pc_plus4 + {imm_sext[29:0], 2'b00};
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_SLL:  begin alu_op = ALU_SLL; wr_en = 1'b1; end
                    F_SRL:  begin alu_op = ALU_SRL; wr_en = 1'b1; end
                    F_SRA:  begin alu_op = ALU_SRA; wr_en = 1'b1; end
                    F_SLLV: begin alu_op = ALU_SLL; var_shift = 1'b1; wr_en = 1'b1; end
                    F_SRLV: begin alu_op = ALU_SRL; var_shift = 1'b1; wr_en = 1'b1; end
                    F_SRAV: begin alu_op = ALU_SRA; var_shift = 1'b1; wr_en = 1'b1; end
                    F_JR:   begin take = 1'b1; target = rs_val; end
                    F_JALR: begin
                        take   = 1'b1;
                        target = rs_val;
                        wr_en  = 1'b1;
                        wb_src = WB_LINK;
                    end
                    F_ADDU: begin alu_op = ALU_ADD;  wr_en = 1'b1; end
                    F_SUBU: begin alu_op = ALU_SUB;  wr_en = 1'b1; end
                    F_AND:  begin alu_op = ALU_AND;  wr_en = 1'b1; end
                    F_OR:   begin alu_op = ALU_OR;   wr_en = 1'b1; end
                    F_XOR:  begin alu_op = ALU_XOR;  wr_en = 1'b1; end
                    F_NOR:  begin alu_op = ALU_NOR;  wr_en = 1'b1; end
                    F_SLT:  begin alu_op = ALU_SLT;  wr_en = 1'b1; end
                    F_SLTU: begin alu_op = ALU_SLTU; wr_en = 1'b1; end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'd0)      take = rs_val[31];
                else if (rt == 5'd1) take = ~rs_val[31];
            end
            OP_J: begin
                take   = 1'b1;
                target = {pc_plus4[31:28], instr_index, 2'b00};
            end
            OP_JAL: begin
                take    = 1'b1;
                target  = {pc_plus4[31:28], instr_index, 2'b00};
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wb_src  = WB_LINK;
            end
            OP_BEQ:  take = (rs_val == rt_val);
            OP_BNE:  take = (rs_val != rt_val);
            OP_BLEZ: take = rs_val[31] | (rs_val == 32'h0);
            OP_BGTZ: take = ~rs_val[31] & (rs_val != 32'h0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                use_imm = 1'b1;
                wr_en   = 1'b1;
                wr_addr = rt;
                case (opcode)
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  begin alu_op = ALU_AND; zext_imm = 1'b1; end
                    OP_ORI:   begin alu_op = ALU_OR;  zext_imm = 1'b1; end
                    OP_XORI:  begin alu_op = ALU_XOR; zext_imm = 1'b1; end
                    OP_LUI:   alu_op = ALU_LUI;
                    default:  alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                is_load = 1'b1;
                wr_en   = 1'b1;
                wr_addr = rt;
                wb_src  = WB_MEM;
            end
            OP_SW: is_store = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] op_b, alu_result, wr_data;
    logic [4:0]  shift_amt;

    assign op_b      = use_imm ? (zext_imm ? imm_zext : imm_sext) : rt_val;
    assign shift_amt = var_shift ? rs_val[4:0] : shamt;

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_result = rs_val + op_b;
            ALU_SUB:  alu_result = rs_val - op_b;
            ALU_AND:  alu_result = rs_val & op_b;
            ALU_OR:   alu_result = rs_val | op_b;
            ALU_XOR:  alu_result = rs_val ^ op_b;
            ALU_NOR:  alu_result = ~(rs_val | op_b);
            ALU_SLT:  alu_result = {31'h0, $signed(rs_val) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'h0, rs_val < op_b};
            ALU_SLL:  alu_result = rt_val << shift_amt;
            ALU_SRL:  alu_result = rt_val >> shift_amt;
            ALU_SRA:  alu_result = $unsigned($signed(rt_val) >>> shift_amt);
            ALU_LUI:  alu_result = {imm, 16'h0};
            default:  alu_result = 32'h0;
        endcase
    end

    always_comb begin
        wr_data = alu_result;
        case (wb_src)
            WB_MEM:  wr_data = data_readdata;
            WB_LINK: wr_data = pc_plus8;
            default: wr_data = alu_result;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        active_d      = active_q;
        if (active_q) begin
            pc_d          = seq_pc;
            pend_valid_d  = take;
            pend_target_d = take ? target : pend_target_q;
            // Advancing to address 0 is the halt condition.
            if (seq_pc == 32'h0) begin
                pc_d     = 32'h0;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            active_q      <= 1'b1;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            active_q      <= active_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
        end else if (active_q && wr_en && (wr_addr != 5'd0)) begin
            gpr_q[wr_addr] <= wr_data;
        end
    end

    assign active         = active_q;
    assign register_v0    = gpr_q[2];
    assign instr_address  = pc_q;
    assign data_address   = rs_val + imm_sext;
    assign data_read      = active_q & is_load & ~reset;
    assign data_write     = active_q & is_store & ~reset;
    assign data_writedata = data_write ? rt_val : 32'h0;

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed program bench for mips_cpu_harvard: small instruction ROM and data RAM
// around the core, expected PC/v0 per retired instruction hand-computed.
module tb_mips_cpu_harvard;

    localparam logic [31:0] B = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prog [0:31];
    logic [31:0] dmem [0:255];
    logic [31:0] ioff;

    mips_cpu_harvard #(.RESET_VECTOR(B)) dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    // Outside the program window the ROM returns LW $2,0($0).
    assign ioff           = instr_address - B;
    assign instr_readdata = (ioff < 32'd128) ? prog[ioff[6:2]] : 32'h8C020000;
    assign data_readdata  = dmem[data_address[9:2]];

    always @(posedge clk) begin
        if (data_write) dmem[data_address[9:2]] <= data_writedata;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc [0:25] = '{
        32'hBFC00004, 32'hBFC00010, 32'hBFC00014, 32'hBFC00018, 32'hBFC0001C,
        32'hBFC00020, 32'hBFC00024, 32'hBFC00028, 32'hBFC00034, 32'hBFC00038,
        32'hBFC0003C, 32'hBFC00040, 32'hBFC00044, 32'hBFC00048, 32'hBFC0004C,
        32'hBFC00050, 32'hBFC00054, 32'hBFC00058, 32'hBFC0005C, 32'hBFC00060,
        32'hBFC00064, 32'hBFC00068, 32'hBFC0006C, 32'hBFC00008, 32'hBFC0000C,
        32'h00000000
    };
    logic [31:0] exp_v0 [0:25] = '{
        32'h00000000, 32'h00007FFF, 32'h00008000, 32'h00008000, 32'h80008000,
        32'h00000001, 32'hBFC00008, 32'hBFC00008, 32'hBFC00008, 32'hBFC00008,
        32'hBFC00008, 32'hBFC00008, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF,
        32'h0FFFFFFF, 32'hF8000000, 32'h00000001, 32'h8000FFFF, 32'hFFFFFF00,
        32'hFFFFFF00, 32'h00000000, 32'h00000000, 32'h00000007, 32'h00000007,
        32'h00000005
    };

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = enc_i(6'h09, 5'd0, 5'd2, 16'h0BAD);
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        prog[0]  = {6'h03, 26'h3F00004};                   // JAL 0xBFC00010
        prog[1]  = enc_i(6'h09, 5'd0, 5'd2, 16'h7FFF);     // ADDIU $2,$0,0x7FFF
        prog[2]  = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);   // JR $0
        prog[3]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0005);     // ADDIU $2,$0,5
        prog[4]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);     // ADDIU $2,$2,1
        prog[5]  = enc_i(6'h0F, 5'd0, 5'd3, 16'h8000);     // LUI $3,0x8000
        prog[6]  = enc_r(5'd2, 5'd3, 5'd2, 5'd0, 6'h21);   // ADDU $2,$2,$3
        prog[7]  = enc_r(5'd3, 5'd0, 5'd2, 5'd0, 6'h2A);   // SLT $2,$3,$0
        prog[8]  = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);  // ADDU $2,$31,$0
        prog[9]  = enc_i(6'h04, 5'd0, 5'd0, 16'h0003);     // BEQ $0,$0,+3
        prog[10] = enc_i(6'h09, 5'd0, 5'd5, 16'h0100);     // ADDIU $5,$0,0x100
        prog[13] = enc_i(6'h0F, 5'd0, 5'd4, 16'hDEAD);     // LUI $4,0xDEAD
        prog[14] = enc_i(6'h0D, 5'd4, 5'd4, 16'hBEEF);     // ORI $4,$4,0xBEEF
        prog[15] = enc_i(6'h2B, 5'd5, 5'd4, 16'h0008);     // SW $4,8($5)
        prog[16] = enc_i(6'h23, 5'd5, 5'd2, 16'h0008);     // LW $2,8($5)
        prog[17] = enc_i(6'h05, 5'd2, 5'd4, 16'h0005);     // BNE $2,$4,+5
        prog[18] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF);     // ADDIU $2,$0,-1
        prog[19] = enc_r(5'd0, 5'd2, 5'd2, 5'd4, 6'h02);   // SRL $2,$2,4
        prog[20] = enc_r(5'd0, 5'd3, 5'd2, 5'd4, 6'h03);   // SRA $2,$3,4
        prog[21] = enc_i(6'h0B, 5'd0, 5'd2, 16'hFFFF);     // SLTIU $2,$0,-1
        prog[22] = enc_i(6'h0E, 5'd3, 5'd2, 16'hFFFF);     // XORI $2,$3,0xFFFF
        prog[23] = enc_r(5'd0, 5'd5, 5'd2, 5'd0, 6'h23);   // SUBU $2,$0,$5
        prog[24] = enc_i(6'h09, 5'd0, 5'd0, 16'h0005);     // ADDIU $0,$0,5
        prog[25] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h21);   // ADDU $2,$0,$0
        prog[26] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);  // JR $31
        prog[27] = enc_i(6'h09, 5'd0, 5'd2, 16'h0007);     // ADDIU $2,$0,7

        clk_enable = 1'b1;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_pc", instr_address, B);
        check_val("reset_active", {31'h0, active}, 32'h1);
        check_val("reset_v0", register_v0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            if (i == 11) begin
                check_val("sw_write", {31'h0, data_write}, 32'h1);
                check_val("sw_read", {31'h0, data_read}, 32'h0);
                check_val("sw_addr", data_address, 32'h00000108);
                check_val("sw_wdata", data_writedata, 32'hDEADBEEF);
            end
            if (i == 12) begin
                check_val("lw_read", {31'h0, data_read}, 32'h1);
                check_val("lw_write", {31'h0, data_write}, 32'h0);
                check_val("lw_wdata", data_writedata, 32'h0);
            end
            step();
            $display("step %0d pc=%08h v0=%08h active=%0b", i + 1, instr_address,
                     register_v0, active);
            check_val($sformatf("pc_%0d", i + 1), instr_address, exp_pc[i]);
            check_val($sformatf("v0_%0d", i + 1), register_v0, exp_v0[i]);
            check_val($sformatf("active_%0d", i + 1), {31'h0, active},
                      (i == 25) ? 32'h0 : 32'h1);
        end

        for (int i = 0; i < 3; i++) begin
            step();
            $display("halted %0d pc=%08h v0=%08h active=%0b", i, instr_address,
                     register_v0, active);
            check_val("halt_pc", instr_address, 32'h0);
            check_val("halt_v0", register_v0, 32'h5);
            check_val("halt_active", {31'h0, active}, 32'h0);
            check_val("halt_rd", {31'h0, data_read}, 32'h0);
            check_val("halt_wr", {31'h0, data_write}, 32'h0);
        end

        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("restart reset pc=%08h v0=%08h active=%0b", instr_address, register_v0, active);
        check_val("restart_pc", instr_address, B);
        check_val("restart_active", {31'h0, active}, 32'h1);
        check_val("restart_v0", register_v0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 40 && instr_address != 32'hBFC00040; c++) step();
        check_val("rerun_lw_pc", instr_address, 32'hBFC00040);
        check_val("rerun_lw_read", {31'h0, data_read}, 32'h1);
        check_val("rerun_v0", register_v0, 32'hBFC00008);

        #2;
        reset = 1'b1;
        #1;
        $display("midrun reset pc=%08h v0=%08h rd=%0b wr=%0b", instr_address, register_v0,
                 data_read, data_write);
        check_val("mid_pc", instr_address, B);
        check_val("mid_active", {31'h0, active}, 32'h1);
        check_val("mid_v0", register_v0, 32'h0);
        check_val("mid_rd", {31'h0, data_read}, 32'h0);
        check_val("mid_wr", {31'h0, data_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_harvard.md
Name: mips_cpu_harvard

Overview:
Single-cycle MIPS-I integer core with separate instruction and data ports (Harvard). Each rising clk edge retires one instruction: fetch, decode, execute, memory access and register writeback all complete combinationally within the cycle. It sits inside the Avalon bus wrapper, which supplies instruction and data words, gates the core clock, and sequences the bus.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
active  output  1  high while executing; low once halted.
register_v0  output  32  continuous copy of register $2 ($v0) for debug.
clk_enable  input  1  reserved and ignored; the core advances on every clk edge.
instr_address  output  32  current PC; word aligned.
instr_readdata  input  32  instruction at instr_address, valid in the same cycle.
data_address  output  32  load/store effective address (rs + sign-extended imm16).
data_write  output  1  high during SW.
data_read  output  1  high during LW.
data_writedata  output  32  rt value during SW; 0 otherwise.
data_readdata  input  32  load data for data_address, valid in the same cycle.

Behaviour:
- Reset (asynchronous, active-high): PC=RESET_VECTOR, delay-slot target register cleared, all 32 GPRs=0, active=1. Outputs follow combinationally: instr_address=RESET_VECTOR, data_read=data_write=0 while reset is asserted. Reset asserted mid-operation aborts the current instruction; no register write occurs.
- $0 reads as 0 always; writes to it are discarded.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, LW, SW.
  - J-type: J, JAL.
- Unsupported opcodes execute as NOP.
- Arithmetic: 32-bit wraparound, no overflow traps.
  - ANDI/ORI/XORI zero-extend imm16; all other immediates sign-extend.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned on the sign-extended immediate.
  - Shifts use shamt, or rs[4:0] for the V forms.
  - LUI result = {imm16, 16'h0}.
- Branch delay slot: the instruction after any taken branch or jump always executes. Then PC = target.
  - Branch target = PC+4 + (sext(imm16)<<2).
  - J/JAL target = {(PC+4)[31:28], instr_index, 2'b00}.
  - JR/JALR target = rs.
  - JAL writes PC+8 to $31. JALR writes PC+8 to rd.
- Implement with registers PC plus a pending-target valid/value pair, updated each posedge.
- Branch/jump in a delay slot: undefined usage. The core may let the newer target overwrite the pending one.
- LW: data_read=1 combinationally in the same cycle; data_readdata is written to rt at the posedge. SW: data_write=1, data_writedata=rt; no register write. data_read and data_write are never both 1.
- Halt: when the PC would advance to 32'h00000000, at that edge PC is set to 0 and active drops to 0.
  - While active=0: PC, GPRs and pending target are frozen; data_read=data_write=0; register_v0 holds its value.
  - Only reset restarts the core.
- Word accesses only; no byte enables. Address alignment is not checked.

Test Plan:
- Reset: assert reset mid-run -> instr_address=0xBFC00000, active=1, register_v0=0, data_read=data_write=0 immediately.
- ALU: ADDIU $2,$0,0x7FFF; ADDIU $2,$2,1; LUI $3,0x8000; ADDU $2,$2,$3 -> v0=0x00007FFF, 0x00008000, then 0x80008000. A following SLT $2,$3,$0 -> v0=1.
- Memory: SW $4,8($5) with $5=0x100, $4=0xDEADBEEF -> data_write=1, data_address=0x108, data_writedata=0xDEADBEEF. LW $2,8($5) with data_readdata=0xDEADBEEF -> data_read=1, then v0=0xDEADBEEF.
- Branches: BEQ $0,$0,+3 at 0xBFC00010 -> 0xBFC00014 (delay slot) executes, then PC=0xBFC00020. BNE on equal operands -> sequential PC.
- Link: JAL at 0xBFC00000 -> $31=0xBFC00008. JR $31 from the target returns after its delay slot.
- Halt: JR $0 with ADDIU $2,$0,5 in the delay slot -> v0=5, PC=0, active falls to 0. Further clocks change nothing; data_read and data_write stay 0.
